// File: rtl/gf_poly_reducer.sv
// gf_poly_reducer: bit-serial reduction of a 2*DATA_WIDTH-bit carry-less
// product modulo the monic polynomial x^DATA_WIDTH + in_poly. The block
// examines one product bit per enabled cycle, from the MSB downwards, and
// uses valid/ready handshakes on both sides.
module gf_poly_reducer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [2*DATA_WIDTH-1:0]   in_prod,
    input  logic [DATA_WIDTH-1:0]     in_poly,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(2 * DATA_WIDTH);

    localparam logic [CW-1:0] LAST_CNT  = CW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] TOP_IDX   = IW'(2 * DATA_WIDTH - 1);
    localparam logic [IW-1:0] MAX_SHIFT = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t                    state, state_n;
    logic [2*DATA_WIDTH-1:0]   rem, rem_n;
    logic [DATA_WIDTH-1:0]     poly, poly_n;
    logic [CW-1:0]             cnt, cnt_n;

    logic [IW-1:0]             bit_idx;
    logic [IW-1:0]             shamt;
    logic [2*DATA_WIDTH-1:0]   poly_mask;

    // Align the full modulus {1,poly} so its leading 1 sits on the bit under test.
    always_comb begin
        bit_idx   = TOP_IDX - IW'(cnt);
        shamt     = MAX_SHIFT - IW'(cnt);
        poly_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1, poly} << shamt;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_n    = state;
        rem_n      = rem;
        poly_n     = poly;
        cnt_n      = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_result = rem[DATA_WIDTH-1:0];

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_n   = in_prod;
                    poly_n  = in_poly;
                    cnt_n   = '0;
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                busy = 1'b1;
                if (rem[bit_idx]) begin
                    rem_n = rem ^ poly_mask;
                end
                cnt_n = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; everything holds while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            poly  <= '0;
            cnt   <= '0;
        end else if (enable) begin
            state <= state_n;
            rem   <= rem_n;
            poly  <= poly_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_gf_poly_reducer.sv
// Directed bench for gf_poly_reducer: an 8-bit instance for the AES-field
// vectors, handshake and stall scenarios, and a 32-bit instance fed with
// carry-less products checked against an independent GF multiply model.
module tb_gf_poly_reducer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;

    logic [15:0] prod8 = '0;
    logic [7:0]  poly8 = '0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  result8;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic        busy8;

    logic [63:0] prod32 = '0;
    logic [31:0] poly32 = '0;
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] result32;
    logic        out_valid32;
    logic        out_ready32 = 1'b0;
    logic        busy32;

    int checks = 0;
    int errors = 0;

    gf_poly_reducer #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable),
        .in_prod(prod8), .in_poly(poly8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_result(result8), .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8)
    );

    gf_poly_reducer #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .enable(enable),
        .in_prod(prod32), .in_poly(poly32), .in_valid(in_valid32), .in_ready(in_ready32),
        .out_result(result32), .out_valid(out_valid32), .out_ready(out_ready32), .busy(busy32)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand to the 8-bit instance and wait (bounded) for out_valid.
    task automatic issue8(input logic [15:0] p, input logic [7:0] m, output int lat);
        prod8     = p;
        poly8     = m;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    function automatic logic [63:0] clmul32(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) r = r ^ (64'(a) << i);
        return r;
    endfunction

    // Horner-style shift-XOR multiply in GF(2^32); reduces after every shift.
    function automatic logic [31:0] gfmul32(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] p);
        logic [31:0] r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (r[31]) r = (r << 1) ^ p;
            else       r = r << 1;
            if (b[i])  r = r ^ a;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || result8 !== 8'h00) begin
            errors++;
            $display("FAIL reset8: rdy=%b vld=%b busy=%b res=%h, required 1 0 0 00",
                     in_ready8, out_valid8, busy8, result8);
        end
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || busy32 !== 1'b0 || result32 !== 32'h0) begin
            errors++;
            $display("FAIL reset32: rdy=%b vld=%b busy=%b res=%h, required 1 0 0 0",
                     in_ready32, out_valid32, busy32, result32);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_aes_vector();
        int lat;
        issue8(16'h2B79, 8'h1B, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL aes_latency: got %0d cycles, required 8", lat);
        end
        checks++;
        if (result8 !== 8'hC1 || busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL aes_result: got %h busy=%b rdy=%b, required c1 1 0", result8, busy8, in_ready8);
        end
        consume8();
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL aes_consume: vld=%b rdy=%b busy=%b, required 0 1 0", out_valid8, in_ready8, busy8);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] prods [4] = '{16'h00A5, 16'h0100, 16'h8000, 16'h0000};
        logic [7:0]  exps  [4] = '{8'hA5,   8'h1B,   8'h2F,   8'h00};
        int lat;
        for (int k = 0; k < 4; k++) begin
            issue8(prods[k], 8'h1B, lat);
            checks++;
            if (lat !== 8 || result8 !== exps[k]) begin
                errors++;
                $display("FAIL boundary_%0d: prod=%h got %h after %0d cycles, required %h after 8",
                         k, prods[k], result8, lat, exps[k]);
            end
            consume8();
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        issue8(16'h2B79, 8'h1B, lat);
        for (int k = 0; k < 5; k++) begin
            prod8     = 16'h1234;
            in_valid8 = 1'b1;
            tick();
            checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || result8 !== 8'hC1) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: vld=%b rdy=%b res=%h, required 1 0 c1",
                         k, out_valid8, in_ready8, result8);
            end
        end
        in_valid8 = 1'b0;
        consume8();
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: vld=%b rdy=%b, required 0 1", out_valid8, in_ready8);
        end
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_ignored: busy=%b, required 0", busy8);
        end
    endtask

    task automatic test_enable_stall();
        int n;
        logic stall_ok;
        prod8     = 16'h2B79;
        poly8     = 8'h1B;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        stall_ok = 1'b1;
        while (!out_valid8 && n < 100) begin
            enable = (n >= 3 && n < 6) ? 1'b0 : 1'b1;
            tick();
            n++;
            if (!enable && (busy8 !== 1'b1 || out_valid8 !== 1'b0)) stall_ok = 1'b0;
        end
        enable = 1'b1;
        checks++;
        if (n !== 11 || result8 !== 8'hC1 || stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL enable_stall: got %h after %0d cycles (stall_ok=%b), required c1 after 11",
                     result8, n, stall_ok);
        end
        // A disabled cycle must not complete the output handshake.
        enable     = 1'b0;
        out_ready8 = 1'b1;
        tick();
        checks++;
        if (out_valid8 !== 1'b1) begin
            errors++;
            $display("FAIL enable_handshake: vld=%b, required 1", out_valid8);
        end
        enable = 1'b1;
        tick();
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL enable_consume: vld=%b rdy=%b, required 0 1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic seen;
        prod8     = 16'h2B79;
        poly8     = 8'h1B;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy=%b vld=%b rdy=%b, required 0 0 1", busy8, out_valid8, in_ready8);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid8 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: stray out_valid=%b, required 0", seen);
        end
        issue8(16'h2B79, 8'h1B, lat);
        checks++;
        if (lat !== 8 || result8 !== 8'hC1) begin
            errors++;
            $display("FAIL reset_next_op: got %h after %0d cycles, required c1 after 8", result8, lat);
        end
        consume8();
    endtask

    task automatic test_chained_random();
        logic [31:0] a, b, expv;
        int lat;
        poly32 = 32'h0000008D;
        for (int k = 0; k < 100; k++) begin
            a          = $urandom;
            b          = $urandom;
            expv       = gfmul32(a, b, 32'h0000008D);
            prod32     = clmul32(a, b);
            in_valid32 = 1'b1;
            tick();
            in_valid32 = 1'b0;
            lat = 0;
            while (!out_valid32 && lat < 100) begin
                tick();
                lat++;
            end
            checks++;
            if (lat !== 32 || result32 !== expv) begin
                errors++;
                $display("FAIL chained_%0d: a=%h b=%h got %h after %0d cycles, required %h after 32",
                         k, a, b, result32, lat, expv);
            end
            out_ready32 = 1'b1;
            tick();
            out_ready32 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_aes_vector();
        test_boundaries();
        test_back_pressure();
        test_enable_stall();
        test_reset_mid_op();
        test_chained_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
